// File: rtl/onstate_ontransit_multi.sv
// Multi-channel IDLE/RUN/LAST activity tracker with combinational stop pulse,
// registered on-state flags, configurable LAST hold, retrigger and saturating run length.
module onstate_ontransit_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LAST_LEN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   retrig_i,
  input  logic [NCH-1:0]         do_i,
  output logic [NCH-1:0]         g_o,
  output logic [NCH-1:0]         r_o,
  output logic [NCH-1:0]         f_o,
  output logic [NCH-1:0]         len_vld_o,
  output logic [NCH*CNT_W-1:0]   len_out_o
);

  localparam int unsigned LCW = (LAST_LEN > 1) ? $clog2(LAST_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_e;

  state_e               state_q [NCH];
  state_e               state_d [NCH];
  logic [LCW-1:0]       lcnt_q  [NCH];
  logic [LCW-1:0]       lcnt_d  [NCH];
  logic [CNT_W-1:0]     rcnt_q  [NCH];
  logic [CNT_W-1:0]     rcnt_d  [NCH];
  logic [NCH-1:0]       r_q, r_d;
  logic [NCH-1:0]       f_q, f_d;
  logic [NCH-1:0]       len_vld_q, len_vld_d;
  logic [NCH*CNT_W-1:0] len_out_q, len_out_d;
  logic [NCH-1:0]       g_c;

  // State and status registers for all channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c] <= S_IDLE;
        lcnt_q[c]  <= '0;
        rcnt_q[c]  <= '0;
      end
      r_q       <= '0;
      f_q       <= '0;
      len_vld_q <= '0;
      len_out_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        lcnt_q[c]  <= lcnt_d[c];
        rcnt_q[c]  <= rcnt_d[c];
      end
      r_q       <= r_d;
      f_q       <= f_d;
      len_vld_q <= len_vld_d;
      len_out_q <= len_out_d;
    end
  end

  // Per-channel next-state, counters and decoded outputs; clr overrides all channels
  always_comb begin
    len_out_d = len_out_q;
    g_c       = '0;
    len_vld_d = '0;
    r_d       = '0;
    f_d       = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      lcnt_d[c]  = lcnt_q[c];
      rcnt_d[c]  = rcnt_q[c];
      case (state_q[c])
        S_IDLE: begin
          if (do_i[c]) begin
            state_d[c] = S_RUN;
            rcnt_d[c]  = CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!do_i[c]) begin
            state_d[c]   = S_LAST;
            lcnt_d[c]    = LCW'(LAST_LEN - 1);
            g_c[c]       = 1'b1;
            len_vld_d[c] = 1'b1;
            len_out_d[c*CNT_W +: CNT_W] = rcnt_q[c];
          end else if (rcnt_q[c] != '1) begin
            rcnt_d[c] = rcnt_q[c] + CNT_W'(1);
          end
        end
        S_LAST: begin
          // Retrigger wins over expiry of the hold
          if (retrig_i && do_i[c]) begin
            state_d[c] = S_RUN;
            rcnt_d[c]  = CNT_W'(1);
          end else if (lcnt_q[c] == '0) begin
            state_d[c] = S_IDLE;
          end else begin
            lcnt_d[c] = lcnt_q[c] - LCW'(1);
          end
        end
        default: state_d[c] = S_IDLE;
      endcase
      if (clr_i) begin
        state_d[c]   = S_IDLE;
        lcnt_d[c]    = '0;
        rcnt_d[c]    = '0;
        g_c[c]       = 1'b0;
        len_vld_d[c] = 1'b0;
        len_out_d[c*CNT_W +: CNT_W] = len_out_q[c*CNT_W +: CNT_W];
      end
      r_d[c] = (state_d[c] == S_RUN);
      f_d[c] = (state_d[c] == S_LAST);
    end
  end

  assign g_o       = g_c;
  assign r_o       = r_q;
  assign f_o       = f_q;
  assign len_vld_o = len_vld_q;
  assign len_out_o = len_out_q;

endmodule

// File: tb/tb_onstate_ontransit_multi.sv
// Directed self-checking bench for onstate_ontransit_multi (NCH=2, CNT_W=4, LAST_LEN=3).
module tb_onstate_ontransit_multi;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       retrig;
  logic [1:0] do_v;
  logic [1:0] g, r, f, len_vld;
  logic [7:0] len_out;

  int n_tests;
  int n_fail;
  int cyc;
  int cnt_a, cnt_b;

  onstate_ontransit_multi #(.NCH(2), .CNT_W(4), .LAST_LEN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .retrig_i  (retrig),
    .do_i      (do_v),
    .g_o       (g),
    .r_o       (r),
    .f_o       (f),
    .len_vld_o (len_vld),
    .len_out_o (len_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check reset values, release; returns at start of cycle 0
  task automatic restart();
    rst_n = 1'b0;
    do_v  = 2'b00;
    clr   = 1'b0;
    #1;
    cyc = -1;
    chk("rst_r", 32'(r), 0);
    chk("rst_f", 32'(f), 0);
    chk("rst_g", 32'(g), 0);
    chk("rst_len_vld", 32'(len_vld), 0);
    chk("rst_len_out", 32'(len_out), 0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    retrig  = 1'b0;
    rst_n   = 1'b0;
    do_v    = 2'b00;
    clr     = 1'b0;
    next_cycle();

    // Basic run on channel 0
    restart();
    for (int c = 0; c < 14; c++) begin
      cyc = c;
      do_v = {1'b0, (c >= 2 && c <= 6)};
      #1;
      chk("basic_r0", 32'(r[0]), 32'(c >= 3 && c <= 7));
      chk("basic_g0", 32'(g[0]), 32'(c == 7));
      chk("basic_f0", 32'(f[0]), 32'(c >= 8 && c <= 10));
      chk("basic_vld0", 32'(len_vld[0]), 32'(c == 8));
      if (c == 8) chk("basic_len0", 32'(len_out[3:0]), 5);
      chk("basic_ch1", 32'({g[1], r[1], f[1], len_vld[1], len_out[7:4]}), 0);
      next_cycle();
    end

    // Saturation on channel 1
    restart();
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 27; c++) begin
      cyc = c;
      do_v = {(c >= 2 && c <= 21), 1'b0};
      #1;
      if (r[1]) cnt_a++;
      if (len_vld[1]) cnt_b++;
      chk("sat_r1", 32'(r[1]), 32'(c >= 3 && c <= 22));
      if (c == 23) begin
        chk("sat_vld1", 32'(len_vld[1]), 1);
        chk("sat_len1", 32'(len_out[7:4]), 15);
      end
      next_cycle();
    end
    chk("sat_r1_cycles", 32'(cnt_a), 20);
    chk("sat_vld1_pulses", 32'(cnt_b), 1);
    chk("sat_ch0", 32'({r[0], f[0], len_out[3:0]}), 0);

    // Retrigger from LAST
    restart();
    retrig = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cyc = c;
      do_v = {1'b0, ((c >= 2 && c <= 6) || c == 9)};
      #1;
      chk("rt_r0", 32'(r[0]), 32'((c >= 3 && c <= 7) || c == 10));
      chk("rt_f0", 32'(f[0]), 32'((c >= 8 && c <= 9) || (c >= 11 && c <= 13)));
      chk("rt_g0", 32'(g[0]), 32'(c == 7 || c == 10));
      chk("rt_vld0", 32'(len_vld[0]), 32'(c == 8 || c == 11));
      if (c >= 3 && c <= 13) chk("rt_no_idle", 32'(r[0] | f[0]), 1);
      if (c == 8 || c == 10) chk("rt_len0_first", 32'(len_out[3:0]), 5);
      if (c == 11) chk("rt_len0_second", 32'(len_out[3:0]), 1);
      next_cycle();
    end
    retrig = 1'b0;

    // Same stimulus shape without retrigger: do ignored in LAST
    restart();
    for (int c = 0; c < 18; c++) begin
      cyc = c;
      do_v = {1'b0, ((c >= 2 && c <= 6) || (c >= 9 && c <= 11))};
      #1;
      chk("nrt_r0", 32'(r[0]), 32'((c >= 3 && c <= 7) || c == 12));
      chk("nrt_f0", 32'(f[0]), 32'((c >= 8 && c <= 10) || (c >= 13 && c <= 15)));
      chk("nrt_g0", 32'(g[0]), 32'(c == 7 || c == 12));
      if (c == 13) chk("nrt_len0", 32'({len_vld[0], len_out[3:0]}), 32'h11);
      next_cycle();
    end

    // Abort: clr in cycle 5 with ch0 in RUN (do dropping) and ch1 in LAST
    for (int c = 0; c < 15; c++) begin
      cyc = c;
      do_v = {(c >= 1 && c <= 2), ((c >= 2 && c <= 4) || (c >= 8 && c <= 9))};
      clr = (c == 5);
      #1;
      if (c == 4) chk("ab_len1", 32'({len_vld[1], len_out[7:4]}), 32'h12);
      if (c == 5) begin
        chk("ab_pre_r0", 32'(r[0]), 1);
        chk("ab_pre_f1", 32'(f[1]), 1);
        chk("ab_g_forced", 32'(g), 0);
      end
      if (c >= 6 && c <= 8) begin
        chk("ab_rf", 32'({r, f}), 0);
        chk("ab_no_vld", 32'(len_vld), 0);
        chk("ab_len_hold", 32'(len_out), 32'h21);
      end
      if (c == 10) chk("ab_resume_g0", 32'(g[0]), 1);
      if (c == 11) chk("ab_resume_len0", 32'({len_vld[0], f[0], len_out[3:0]}), 32'h32);
      next_cycle();
    end
    clr = 1'b0;

    // Async reset mid-LAST, then a 1-cycle pulse
    restart();
    for (int c = 0; c < 13; c++) begin
      cyc = c;
      do_v = {1'b0, ((c >= 1 && c <= 2) || c == 7)};
      #1;
      if (c == 4) chk("ar_in_last", 32'({f[0], len_vld[0], len_out[3:0]}), 32'h32);
      if (c == 5) begin
        rst_n = 1'b0;
        #1;
        chk("ar_rf", 32'({r, f}), 0);
        chk("ar_vld", 32'(len_vld), 0);
        chk("ar_len", 32'(len_out), 0);
        #1;
        rst_n = 1'b1;
      end
      chk("ar_r0", 32'(r[0]), 32'((c >= 2 && c <= 3) || c == 8));
      chk("ar_g0", 32'(g[0]), 32'(c == 3 || c == 8));
      if (c == 9) chk("ar_pulse_len", 32'({len_vld[0], len_out[3:0]}), 32'h11);
      chk("ar_f0", 32'(f[0]), 32'(c == 4 || (c >= 9 && c <= 11)));
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onstate_ontransit_multi.md
Name: onstate_ontransit_multi

Overview:
- Multi-channel generalisation of the IDLE/RUN/LAST activity tracker.
- Each of NCH independent channels runs its own copy of the FSM and provides:
  - a combinational on-transition pulse;
  - registered on-state flags decoded from the next state;
  - a LAST hold of configurable length;
  - an optional retrigger from LAST;
  - a saturating run-length measurement per run.
- Sits between input qualifiers and control/status logic that needs per-channel start, stop and duration information.

Parameters:
- NCH, 4, number of independent channels (>=1).
- CNT_W, 8, width of each channel's run-length counter/output (>=2).
- LAST_LEN, 1, cycles spent in LAST before returning to IDLE (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; all channels return to IDLE.
- retrig  input  1  1: do re-asserted in LAST returns the channel to RUN. 0: do is ignored in LAST.
- do  input  NCH  per-channel activity request; bit c is channel c.
- g  output  NCH  combinational pulse on the RUN->LAST transition.
- r  output  NCH  registered; 1 while the channel is in RUN.
- f  output  NCH  registered; 1 while the channel is in LAST.
- len_vld  output  NCH  registered 1-cycle pulse; len_out for that channel is updated.
- len_out  output  NCH*CNT_W  registered run length; channel c occupies [c*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n=0, asynchronous):
  - every channel state=IDLE, LAST counter=0, run counter=0;
  - r=0, f=0, len_vld=0, len_out=0;
  - g=0 because state is IDLE.
- State is 2 bits per channel: IDLE, RUN, LAST. Channels are fully independent; only clr and retrig are shared.
- Next-state rules per channel c, evaluated each cycle; clr overrides everything:
  - IDLE: if do[c]=1, go to RUN; else stay in IDLE.
  - RUN: if do[c]=0, go to LAST and drive g[c]=1 combinationally in the same cycle; else stay in RUN.
  - LAST:
    - if retrig=1 and do[c]=1, go to RUN (has priority over expiry);
    - else if the LAST counter is 0, go to IDLE;
    - else stay in LAST and decrement the counter.
- LAST counter: loaded with LAST_LEN-1 on RUN->LAST. LAST therefore occupies exactly LAST_LEN cycles when not retriggered.
- g[c] is a pure decode of state and do[c]. It is forced to 0 when clr=1.
- r[c] and f[c] are registered from nextstate (RUN and LAST respectively). They are visible one cycle after nextstate changes, i.e. aligned with state.
- Run counter:
  - loaded with 1 on any transition into RUN (from IDLE or via retrigger);
  - incremented on each cycle the channel is in RUN with do[c]=1;
  - saturates at 2^CNT_W-1 and never wraps.
  - The result equals the number of consecutive cycles do[c] was sampled high, saturated.
- On RUN->LAST: len_out[c] <= run counter value and len_vld[c] <= 1 for one cycle. Both become visible together with the first cycle of f[c]=1.
- len_out holds its value until the next completed run. A retrigger does not clear len_out.
- clr=1 (synchronous):
  - all nextstate=IDLE; registered r, f, len_vld become 0 next cycle;
  - no len_vld and no len_out update for a run aborted by clr;
  - LAST and run counters cleared.
- do[c] is assumed synchronous to clk; no internal synchroniser.
- A 1-cycle do pulse in IDLE gives: RUN for 1 cycle, g in that cycle, len_out=1.

Test Plan:
- Basic run. Setup: NCH=2, CNT_W=4, LAST_LEN=3, retrig=0. Stimulus: do[0]=1 in cycles 2-6. Required:
  - r[0]=1 in cycles 3-7;
  - g[0]=1 in cycle 7 only;
  - f[0]=1 in cycles 8-10, IDLE in cycle 11;
  - len_vld[0]=1 in cycle 8 with len_out[0]=5;
  - channel 1 outputs stay 0.
- Saturation. Same setup, do[1]=1 for 20 cycles. Required: len_out[1]=15 with a single len_vld[1] pulse; r[1] high 20 cycles.
- Retrigger. Same setup, retrig=1, do[0] high cycles 2-6, then high again in cycle 9. Required:
  - f[0]=1 cycles 8-9, r[0]=1 from cycle 10, no IDLE visit;
  - the second run's len_out counts from 1.
- No retrigger. Same stimulus with retrig=0. Required:
  - do ignored in LAST, f[0]=1 cycles 8-10;
  - if do[0] is still high in cycle 11, r[0]=1 from cycle 12.
- Abort. clr=1 in cycle 5 during a channel-0 RUN and a channel-1 LAST. Required:
  - r, f = 0 from cycle 6;
  - no g pulse, no len_vld, len_out unchanged;
  - normal operation resumes on the next do.
- Async reset mid-LAST: r, f, len_vld, len_out all 0 immediately; 1-cycle do pulse afterwards gives g and len_out=1.
